// File: rtl/rom_read_scheduler.sv
// rom_read_scheduler: round-robin, credit-throttled fetch scheduler sharing one
// single-port ROM among per-channel FIFOs.
module rom_read_scheduler #(
    parameter int CHANNELS = 4,
    parameter int CH_LOG   = 2,
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_W*CHANNELS-1:0]   base_addr,
    input  logic [ADDR_W*CHANNELS-1:0]   length,
    input  logic [CHANNELS-1:0]          fifo_rd,
    output logic [ADDR_W-1:0]            rom_addr,
    output logic [CHANNELS-1:0]          wr_en,
    output logic                         busy,
    output logic                         done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q   [CHANNELS];
    logic [ADDR_W-1:0]   addr_d   [CHANNELS];
    logic [ADDR_W-1:0]   rem_q    [CHANNELS];
    logic [ADDR_W-1:0]   rem_d    [CHANNELS];
    logic [CNT_W-1:0]    credit_q [CHANNELS];
    logic [CNT_W-1:0]    credit_d [CHANNELS];
    logic [CH_LOG-1:0]   ptr_q, ptr_d, grant, idx;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [CHANNELS-1:0] wr_en_q, wr_en_d, elig;
    logic                issue, all_zero;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            elig[i] = (state_q == RUN) && (rem_q[i] != '0) && (credit_q[i] < CNT_W'(DEPTH));
    end

    // Scan from farthest to nearest so the first eligible channel after the pointer wins.
    always_comb begin
        grant = ptr_q;
        idx   = ptr_q;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = CH_LOG'((int'(ptr_q) + k) % CHANNELS);
            if (elig[idx]) grant = idx;
        end
        issue = |elig;
    end

    always_comb begin
        ptr_d      = issue ? grant : ptr_q;
        rom_addr_d = issue ? addr_q[grant] : rom_addr_q;
        wr_en_d    = issue ? CHANNELS'(1) << grant : '0;
        all_zero   = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            addr_d[i] = addr_q[i];
            rem_d[i]  = rem_q[i];
            if (state_q == IDLE && start) begin
                addr_d[i] = base_addr[i*ADDR_W +: ADDR_W];
                rem_d[i]  = length[i*ADDR_W +: ADDR_W];
            end else if (issue && grant == CH_LOG'(i)) begin
                addr_d[i] = addr_q[i] + ADDR_W'(1);
                rem_d[i]  = rem_q[i] - ADDR_W'(1);
            end
            credit_d[i] = credit_q[i] + CNT_W'(issue && grant == CH_LOG'(i))
                                      - CNT_W'(fifo_rd[i] && credit_q[i] != '0);
            all_zero = all_zero && (rem_d[i] == '0);
        end
        state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
                  (state_q == RUN)  ? (all_zero ? DRAIN : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= CH_LOG'(CHANNELS - 1);
            rom_addr_q <= '0;
            wr_en_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                addr_q[i]   <= '0;
                rem_q[i]    <= '0;
                credit_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            wr_en_q    <= wr_en_d;
            for (int i = 0; i < CHANNELS; i++) begin
                addr_q[i]   <= addr_d[i];
                rem_q[i]    <= rem_d[i];
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign rom_addr = rom_addr_d;
    assign wr_en    = wr_en_q;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DRAIN;
endmodule

// File: doc/rom_read_scheduler.md
ROM_READ_SCHEDULER -- requirements
Module: rom_read_scheduler

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of consumer channels sharing the value ROM.
REQ-002 The block SHALL have parameter CH_LOG, default 2, ceil(log2(CHANNELS)).
REQ-003 The block SHALL have parameter ADDR_W, default 13, ROM address width.
REQ-004 The block SHALL have parameter DEPTH, default 16, per-channel FIFO depth in words.
REQ-005 The block SHALL have parameter CNT_W, default 5, credit counter width, able to hold DEPTH.
REQ-006 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port start  input  1  one-cycle pulse launching a fetch run.
REQ-009 The block SHALL have port base_addr  input  ADDR_W*CHANNELS  per-channel start address, slice i at [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port length  input  ADDR_W*CHANNELS  per-channel word count, same slicing.
REQ-011 The block SHALL have port fifo_rd  input  CHANNELS  per-channel consumer pop strobe.
REQ-012 The block SHALL have port rom_addr  output  ADDR_W  address to the single-port ROM (1-cycle read latency).
REQ-013 The block SHALL have port wr_en  output  CHANNELS  one-hot FIFO write enables aligned with ROM data out.
REQ-014 The block SHALL have port busy  output  1  high while state is not IDLE.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse at end of run.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-017 IDLE: on start=1, SHALL latch base_addr/length into per-channel addr/remaining registers and go to RUN; busy goes high the next cycle.
REQ-018 start while RUN or DRAIN SHALL be ignored; configuration inputs are only sampled on an accepted start.
REQ-019 Channel i eligible = remaining[i] != 0 AND credit[i] < DEPTH.
REQ-020 RUN: at most one issue per cycle; grant SHALL be round-robin, searching from (last granted + 1) mod CHANNELS, skipping ineligible channels; last-granted pointer resets to CHANNELS-1 (first search starts at channel 0).
REQ-021 Issue to channel g SHALL drive rom_addr = addr[g] combinationally in the issue cycle, then at the edge: addr[g] += 1 (mod 2^ADDR_W, wrap allowed), remaining[g] -= 1, credit[g] += 1.
REQ-022 wr_en SHALL be registered: wr_en[g]=1 exactly one cycle after issue to g, all zeros otherwise; never more than one bit set.
REQ-023 No eligible channel: no issue, rom_addr holds last value, wr_en zero next cycle.
REQ-024 credit[i] SHALL count words issued but not yet popped: +1 on issue, -1 on fifo_rd[i]; both same cycle -> unchanged; fifo_rd[i] with credit[i]=0 -> ignored, no underflow.
REQ-025 Credit SHALL persist across runs (not cleared by start), so unread words from a prior run still throttle issue.
REQ-026 Channels with length 0 SHALL never be granted.
REQ-027 RUN -> DRAIN when all remaining are zero (after the edge of the final issue, or immediately if all lengths are 0).
REQ-028 DRAIN SHALL last exactly one cycle, assert done=1 in that cycle (coincident with the final wr_en, if any), then return to IDLE.
REQ-029 Latency: first issue in the first RUN cycle (cycle after start), first wr_en one cycle later.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, wr_en=0, done=0, busy=0, rom_addr=0, all addr/remaining/credit=0, pointer=CHANNELS-1.
REQ-031 Reset mid-run SHALL abandon the run with no further wr_en; release returns to IDLE awaiting start.

Verification
REQ-032 CHANNELS=4, bases 0/100/200/300, lengths 2 each, fifo_rd held 1 -> issues 0,100,200,300,1,101,201,301 on consecutive cycles; wr_en 0001,0010,0100,1000 repeating lagged one cycle; done with final wr_en.
REQ-033 Channel 1 length 20, no fifo_rd, others 0 -> exactly 16 issues, then stall; one fifo_rd[1] pulse -> exactly one more issue one cycle later.
REQ-034 Lengths 0/3/0/3 -> grants alternate 1,3,1,3,1,3; channels 0 and 2 never granted; 6 wr_en pulses total.
REQ-035 All lengths 0 -> busy for 2 cycles, done in second, wr_en never asserted.
REQ-036 Base 8190 length 4 on channel 0 -> addresses 8190,8191,0,1.
REQ-037 rst_n low during RUN after 3 issues -> wr_en, busy immediately 0; no further writes; new start afterwards runs from fresh configuration.
